// File: rtl/mprj_io_cfg_seq.sv
// mprj_io_cfg_seq
//   Configuration and input-conditioning controller for the user-project GPIO
//   pad array. Each pad has a shadow and an active 13-bit configuration word.
//   Writes land in the shadow copy through a valid/ready port. An apply request
//   then copies shadow to active one pad per cycle, which bounds how many pads
//   switch mode at the same time. Pad inputs pass through a two-flop
//   synchroniser and a per-bit debounce filter before reaching core logic.
//
// Ports
//   clock, reset            single clock; asynchronous active-high reset
//   cfg_valid/cfg_ready     config write handshake (accepted when both high)
//   cfg_idx, cfg_data       target pad and 13-bit config word
//   cfg_apply               request to copy every shadow word to active
//   apply_busy, apply_done  apply sequence running / one-cycle completion pulse
//   cfg_err, err_clr        sticky out-of-range write flag and its clear
//   dm .. analog_pol        per-pad controls decoded from the active words
//   io_in_raw, io_in_filt   asynchronous pad inputs / synchronised, debounced
module mprj_io_cfg_seq #(
    parameter int          NUM_PADS   = 38,
    parameter int          IDX_W      = 6,
    parameter logic [12:0] RST_CFG    = 13'h0402,
    parameter int          DEB_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [IDX_W-1:0]      cfg_idx,
    input  logic [12:0]           cfg_data,
    input  logic                  cfg_apply,
    output logic                  apply_busy,
    output logic                  apply_done,
    output logic                  cfg_err,
    input  logic                  err_clr,
    output logic [3*NUM_PADS-1:0] dm,
    output logic [NUM_PADS-1:0]   oeb,
    output logic [NUM_PADS-1:0]   inp_dis,
    output logic [NUM_PADS-1:0]   ib_mode_sel,
    output logic [NUM_PADS-1:0]   vtrip_sel,
    output logic [NUM_PADS-1:0]   slow_sel,
    output logic [NUM_PADS-1:0]   holdover,
    output logic [NUM_PADS-1:0]   analog_en,
    output logic [NUM_PADS-1:0]   analog_sel,
    output logic [NUM_PADS-1:0]   analog_pol,
    input  logic [NUM_PADS-1:0]   io_in_raw,
    output logic [NUM_PADS-1:0]   io_in_filt
);

    localparam int unsigned      NP     = NUM_PADS;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_PADS - 1);
    localparam int               CNT_W  = (DEB_CYCLES == 0) ? 1 : $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_ptr;
    logic [12:0]      r_shadow [NUM_PADS];
    logic [12:0]      r_active [NUM_PADS];
    logic             r_err;
    logic             w_accept;
    logic             w_idx_ok;
    logic             w_wr_ok;
    logic             w_wr_bad;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        cfg_ready  = 1'b0;
        apply_busy = 1'b0;
        apply_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_apply) begin
                    w_next = S_APPLY;
                end
            end
            S_APPLY: begin
                apply_busy = 1'b1;
                if (r_ptr == LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                apply_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Pointer is held at zero outside APPLY so every sequence starts at pad 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (r_state == S_APPLY) begin
            r_ptr <= r_ptr + IDX_W'(1);
        end else begin
            r_ptr <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Write port and error flag
    // ------------------------------------------------------------------
    assign w_accept = cfg_valid & cfg_ready;
    assign w_idx_ok = (32'(cfg_idx) < NP);
    assign w_wr_ok  = w_accept & w_idx_ok;
    assign w_wr_bad = w_accept & ~w_idx_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_wr_bad) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign cfg_err = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                r_shadow[p] <= RST_CFG;
            end
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                if (w_wr_ok && (cfg_idx == IDX_W'(p))) begin
                    r_shadow[p] <= cfg_data;
                end
            end
        end
    end

    // One pad per APPLY cycle; unchanged pads still take their slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned p = 0; p < NP; p++) begin
                r_active[p] <= RST_CFG;
            end
        end else begin
            for (int unsigned p = 0; p < NP; p++) begin
                if ((r_state == S_APPLY) && (r_ptr == IDX_W'(p))) begin
                    r_active[p] <= r_shadow[p];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pad control decode (active words only; bit 0 is reserved)
    // ------------------------------------------------------------------
    always_comb begin
        dm          = '0;
        analog_pol  = '0;
        analog_sel  = '0;
        analog_en   = '0;
        holdover    = '0;
        slow_sel    = '0;
        vtrip_sel   = '0;
        ib_mode_sel = '0;
        inp_dis     = '0;
        oeb         = '0;
        for (int unsigned p = 0; p < NP; p++) begin
            dm[3*p +: 3]   = r_active[p][12:10];
            analog_pol[p]  = r_active[p][9];
            analog_sel[p]  = r_active[p][8];
            analog_en[p]   = r_active[p][7];
            holdover[p]    = r_active[p][6];
            slow_sel[p]    = r_active[p][5];
            vtrip_sel[p]   = r_active[p][4];
            ib_mode_sel[p] = r_active[p][3];
            inp_dis[p]     = r_active[p][2];
            oeb[p]         = r_active[p][1];
        end
    end

    // ------------------------------------------------------------------
    // Input synchroniser and debounce filter
    // ------------------------------------------------------------------
    logic [NUM_PADS-1:0] r_sync1;
    logic [NUM_PADS-1:0] r_sync2;
    logic [NUM_PADS-1:0] r_filt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_filt <= '0;
                end else begin
                    r_filt <= r_sync2;
                end
            end
        end else begin : g_filter
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
            logic [CNT_W-1:0] r_cnt [NUM_PADS];

            // The output flips on the same edge the counter would reach
            // DEB_CYCLES, so the counter never actually holds that value.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_filt <= '0;
                    for (int unsigned i = 0; i < NP; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < NP; i++) begin
                        if (r_sync2[i] != r_filt[i]) begin
                            if (r_cnt[i] == CNT_LAST) begin
                                r_filt[i] <= r_sync2[i];
                                r_cnt[i]  <= '0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                            end
                        end else begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    assign io_in_filt = r_filt;

endmodule

// File: tb/tb_mprj_io_cfg_seq.sv
// Testbench for mprj_io_cfg_seq: table-driven write vectors, hand-written
// apply / debounce / reset sequences, and randomized traffic checked against
// a cycle-level reference model kept in this file.
module tb_mprj_io_cfg_seq;

    localparam int          NP  = 38;
    localparam int          IW  = 6;
    localparam int          DEB = 4;
    localparam logic [12:0] RST = 13'h0402;

    logic            clock = 1'b0;
    logic            reset;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [IW-1:0]   cfg_idx;
    logic [12:0]     cfg_data;
    logic            cfg_apply;
    logic            apply_busy;
    logic            apply_done;
    logic            cfg_err;
    logic            err_clr;
    logic [3*NP-1:0] dm;
    logic [NP-1:0]   oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover;
    logic [NP-1:0]   analog_en, analog_sel, analog_pol;
    logic [NP-1:0]   io_in_raw;
    logic [NP-1:0]   io_in_filt;

    mprj_io_cfg_seq #(
        .NUM_PADS  (NP),
        .IDX_W     (IW),
        .RST_CFG   (RST),
        .DEB_CYCLES(DEB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_data   (cfg_data),
        .cfg_apply  (cfg_apply),
        .apply_busy (apply_busy),
        .apply_done (apply_done),
        .cfg_err    (cfg_err),
        .err_clr    (err_clr),
        .dm         (dm),
        .oeb        (oeb),
        .inp_dis    (inp_dis),
        .ib_mode_sel(ib_mode_sel),
        .vtrip_sel  (vtrip_sel),
        .slow_sel   (slow_sel),
        .holdover   (holdover),
        .analog_en  (analog_en),
        .analog_sel (analog_sel),
        .analog_pol (analog_pol),
        .io_in_raw  (io_in_raw),
        .io_in_filt (io_in_filt)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: per-pad shadow/active words, error flag, edges since
    // the apply request (-1 when idle), and raw input history per edge.
    logic [12:0]   m_sh  [NP];
    logic [12:0]   m_act [NP];
    logic          m_err;
    int            m_t;
    logic [NP-1:0] m_filt;
    logic [NP-1:0] hist [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] pad_word(input int q);
        return {dm[3*q +: 3], analog_pol[q], analog_sel[q], analog_en[q], holdover[q],
                slow_sel[q], vtrip_sel[q], ib_mode_sel[q], inp_dis[q], oeb[q]};
    endfunction

    task automatic check_pads(input string name);
        logic bad;
        bad = 1'b0;
        n_total++;
        for (int q = 0; q < NP; q++) begin
            if (pad_word(q) !== m_act[q][12:1]) begin
                if (!bad) $display("FAIL %s pad %0d: got %h expected %h",
                                   name, q, pad_word(q), m_act[q][12:1]);
                bad = 1'b1;
            end
        end
        if (!bad) n_pass++;
    endtask

    task automatic check_ctrl(input string name);
        chk({name, "_ready"}, cfg_ready,  m_t < 0);
        chk({name, "_busy"},  apply_busy, (m_t >= 0) && (m_t < NP));
        chk({name, "_done"},  apply_done, m_t == NP);
        chk({name, "_err"},   cfg_err,    m_err);
    endtask

    task automatic model_reset();
        for (int q = 0; q < NP; q++) begin
            m_sh[q]  = RST;
            m_act[q] = RST;
        end
        m_err  = 1'b0;
        m_t    = -1;
        m_filt = '0;
        hist.delete();
        repeat (DEB + 2) hist.push_back('0);
    endtask

    // Model one clock edge from the inputs present at that edge.
    task automatic model_edge();
        int   s;
        logic all_diff;
        logic idle;
        // Filter: sync output seen at this edge is the raw value two edges ago;
        // the output flips once the last DEB such values all differ from it.
        hist.push_back(io_in_raw);
        s = hist.size() - 3;
        for (int b = 0; b < NP; b++) begin
            if (DEB == 0) begin
                m_filt[b] = hist[s][b];
            end else begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (hist[s-j][b] == m_filt[b]) all_diff = 1'b0;
                if (all_diff) m_filt[b] = ~m_filt[b];
            end
        end
        while (hist.size() > DEB + 3) void'(hist.pop_front());
        // Config path
        idle = (m_t < 0);
        if (idle && cfg_valid && (int'(cfg_idx) >= NP)) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (idle) begin
            if (cfg_valid && (int'(cfg_idx) < NP)) m_sh[cfg_idx] = cfg_data;
            if (cfg_apply) m_t = 0;
        end else begin
            m_t++;
            if (m_t <= NP) m_act[m_t-1] = m_sh[m_t-1];
            else m_t = -1;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0;
        cfg_apply = 1'b0;
        err_clr   = 1'b0;
    endtask

    typedef struct {
        int          idx;
        logic [12:0] data;
        logic        clr;
        logic        exp_err;
    } vec_t;

    vec_t        vt [9];
    int          busy_cnt;
    int          done_cnt;
    logic [12:0] w;

    initial begin
        vt[0] = '{5,  13'h1802, 1'b0, 1'b0};
        vt[1] = '{0,  13'h1FFF, 1'b0, 1'b0};
        vt[2] = '{37, 13'h0AAA, 1'b0, 1'b0};
        vt[3] = '{40, 13'h1555, 1'b0, 1'b1};
        vt[4] = '{3,  13'h0F0F, 1'b0, 1'b1};
        vt[5] = '{2,  13'h0000, 1'b1, 1'b0};
        vt[6] = '{63, 13'h1234, 1'b1, 1'b1};
        vt[7] = '{38, 13'h0001, 1'b0, 1'b1};
        vt[8] = '{7,  13'h0C03, 1'b1, 1'b0};

        idle_inputs();
        cfg_idx   = '0;
        cfg_data  = '0;
        io_in_raw = '0;
        reset     = 1'b1;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();

        // Reset state
        check_pads("reset_pads");
        check_ctrl("reset");
        chk("reset_filt", io_in_filt, '0);
        w = RST;
        chk("reset_pad0_dm", dm[2:0], w[12:10]);

        // Write vectors with error flag behaviour; active must stay untouched
        for (int i = 0; i < 9; i++) begin
            cfg_valid = 1'b1;
            cfg_idx   = IW'(vt[i].idx);
            cfg_data  = vt[i].data;
            err_clr   = vt[i].clr;
            step();
            chk($sformatf("vec%0d_err", i), cfg_err, vt[i].exp_err);
            check_pads($sformatf("vec%0d_pads", i));
        end
        idle_inputs();
        step();

        // Apply with a write held through the sequence (pad 7)
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        cfg_valid = 1'b1;
        cfg_idx   = IW'(7);
        cfg_data  = 13'h1C7D;
        busy_cnt  = 0;
        done_cnt  = 0;
        for (int k = 0; k <= NP + 3; k++) begin
            if (k > 0) step();
            check_ctrl($sformatf("apply_k%0d", k));
            check_pads($sformatf("apply_k%0d", k));
            chk($sformatf("pad5_dm_k%0d", k), dm[17:15], (k >= 6) ? 3'b110 : 3'b001);
            if (apply_busy) busy_cnt++;
            if (apply_done) done_cnt++;
            if (k <= NP + 1) chk($sformatf("ready_low_k%0d", k), cfg_ready, k == NP + 1);
        end
        idle_inputs();
        chk("busy_cycles", busy_cnt, NP);
        chk("done_pulses", done_cnt, 1);
        w = 13'h0C03;
        chk("pad7_before_reapply", pad_word(7), w[12:1]);
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        repeat (NP + 2) step();
        check_ctrl("reapply");
        w = 13'h1C7D;
        chk("pad7_after_reapply", pad_word(7), w[12:1]);
        check_pads("reapply_pads");

        // Debounce: 3-cycle glitch is rejected, held level rises on edge 6
        io_in_raw[3] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("glitch_k%0d", k), io_in_filt[3], 1'b0);
        end
        io_in_raw[3] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("glitch_after_k%0d", k), io_in_filt[3], 1'b0);
        end
        io_in_raw[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("deb_rise_k%0d", k), io_in_filt[3], k >= 6);
            chk($sformatf("deb_model_k%0d", k), io_in_filt, m_filt);
        end
        io_in_raw[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("deb_fall_k%0d", k), io_in_filt[3], k < 6);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 300; c++) begin
            cfg_valid = ($urandom % 3) == 0;
            cfg_idx   = ($urandom % 4 == 0) ? IW'($urandom_range(38, 63)) : IW'($urandom_range(0, 37));
            cfg_data  = 13'($urandom);
            err_clr   = ($urandom % 8) == 0;
            cfg_apply = ($urandom % 20) == 0;
            for (int b = 0; b < NP; b++)
                if ($urandom % 6 == 0) io_in_raw[b] = ~io_in_raw[b];
            step();
            check_ctrl("rnd");
            check_pads("rnd");
            chk("rnd_filt", io_in_filt, m_filt);
        end
        idle_inputs();
        repeat (NP + 3) step();

        // Reset in the middle of an apply sequence
        for (int q = 0; q < NP; q++) begin
            cfg_valid = 1'b1;
            cfg_idx   = IW'(q);
            cfg_data  = 13'($urandom) | 13'h0800;
            step();
        end
        idle_inputs();
        cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        repeat (10) step();
        chk("mid_ptr10_pad9", pad_word(9), m_sh[9][12:1]);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_pads("midrst_pads");
        check_ctrl("midrst");
        chk("midrst_filt", io_in_filt, '0);
        step();
        reset    = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < NP + 5; k++) begin
            step();
            if (apply_done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        check_ctrl("midrst_after");
        check_pads("midrst_after_pads");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mprj_io_cfg_seq.md
Name: mprj_io_cfg_seq

Overview:
Parametrised configuration and input-conditioning controller for the user-project GPIO pad array. It holds a shadow and an active 13-bit configuration word per pad. Configuration is written through a valid/ready port. Shadow words are applied to the pad-facing buses one pad per cycle, which bounds simultaneous pad-mode switching. It also synchronises and debounces the pad input bits before they reach core logic. It sits between the management/wishbone register block and the pad-array wrapper, and drives that wrapper's per-pad control buses.

Parameters:
NUM_PADS, 38, number of pads controlled (legal range 2..64).
IDX_W, 6, width of pad index; must satisfy 2^IDX_W >= NUM_PADS.
RST_CFG, 13'h0402, per-pad config after reset (dm=001, oeb=1, everything else 0).
DEB_CYCLES, 4, consecutive stable cycles required before a filtered input changes; 0 bypasses the filter (synchroniser only).

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  write accepted when cfg_valid & cfg_ready
cfg_idx  in  IDX_W  target pad
cfg_data  in  13  config word: [12:10] dm, [9] analog_pol, [8] analog_sel, [7] analog_en, [6] holdover, [5] slow_sel, [4] vtrip_sel, [3] ib_mode_sel, [2] inp_dis, [1] oeb, [0] reserved (stored, not driven)
cfg_apply  in  1  single-cycle request to copy shadow to active
apply_busy  out  1  high while the apply sequence runs
apply_done  out  1  one-cycle pulse when the sequence completes
cfg_err  out  1  sticky flag: an out-of-range index was written
err_clr  in  1  clears cfg_err
dm  out  3*NUM_PADS  active drive mode, pad p at [3p+2:3p]
oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover, analog_en, analog_sel, analog_pol  out  NUM_PADS each  active per-pad controls
io_in_raw  in  NUM_PADS  asynchronous pad inputs
io_in_filt  out  NUM_PADS  synchronised and debounced inputs

Behaviour:
- Reset, asynchronous: all shadow and active words = RST_CFG; FSM = IDLE; cfg_ready=1, apply_busy=0, apply_done=0, cfg_err=0. Sync flops, filter state and io_in_filt = 0.
- Active control outputs are registered decodes of the active words only. Shadow contents never reach the outputs directly.
- Write handshake:
  - In IDLE, cfg_ready=1. A write accepted with cfg_idx < NUM_PADS updates that shadow word on the next edge.
  - A write with cfg_idx >= NUM_PADS is accepted and dropped, and sets cfg_err.
  - If err_clr and an erroring write occur in the same cycle, the set wins.
- FSM:
  - IDLE: cfg_apply=1 -> APPLY, pointer=0. A write accepted in the same cycle as cfg_apply is included in the apply.
  - APPLY: each cycle, active[pointer] <= shadow[pointer] and pointer increments. cfg_ready=0, apply_busy=1, and cfg_apply is ignored. After the pointer=NUM_PADS-1 copy -> DONE.
  - DONE: one cycle with apply_done=1, cfg_ready=0 -> IDLE.
  - Pad p's outputs change at edge p+1 after the cfg_apply edge; the whole sequence spans NUM_PADS+1 cycles until apply_done.
  - Pads whose shadow equals active still consume their slot; no skipping.
- Reset asserted mid-APPLY restores RST_CFG everywhere. No partial state survives.
- Input path, per bit: two-flop synchroniser, then the filter.
  - If the synchronised value differs from io_in_filt, a per-bit counter increments. When the counter reaches DEB_CYCLES, io_in_filt takes the new value and the counter clears.
  - Any cycle where the synchronised value equals io_in_filt clears the counter.
  - Counter width is clog2(DEB_CYCLES+1).
  - With DEB_CYCLES=0, io_in_filt equals the synchronised value: 2-cycle latency, 3 edges from an input change to the output.
  - With the filter on, a clean edge reaches io_in_filt DEB_CYCLES+2 edges after the raw change.
  - The filter operates regardless of inp_dis; the pad itself gates input.

Test Plan:
1. Reset release -> every dm field = 3'b001, all oeb=1, other controls 0, cfg_ready=1, io_in_filt=0.
2. Write pad 5 cfg_data=13'h1802 (dm=110, oeb=1), then cfg_apply -> dm[17:15] unchanged until edge 6 after apply, then 3'b110. apply_busy high NUM_PADS cycles, apply_done pulses once at cycle NUM_PADS+1, cfg_ready low throughout.
3. cfg_valid held high with idx 7 during APPLY -> no accept until back in IDLE; the write lands in shadow only, and active pad 7 is unchanged until the next apply.
4. Write cfg_idx=40 with NUM_PADS=38 -> cfg_err=1 and no shadow changes. err_clr -> 0. err_clr coinciding with another bad write -> stays 1.
5. DEB_CYCLES=4: io_in_raw[3] glitches high for 3 cycles -> io_in_filt[3] stays 0. Held high for 10 cycles -> rises exactly 6 edges after the raw edge.
6. Assert reset at APPLY pointer=10 after writing pads 0..37 -> all outputs return to RST_CFG, FSM IDLE, apply_done never pulses.
